// File: rtl/ram_wport_sched_pkg.sv
// Shared definitions for the RAM write-port scheduler: FSM encoding,
// requester count and packed-slice helpers.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

`define WPS_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package ram_wport_sched_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned NREQ = 4;

    function automatic logic [1:0] rr_after(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/ram_wport_sched_rr_pick4.sv
// Round-robin picker for four requesters: first valid from rr gets port 1,
// next valid one with a different address gets port 2.
module rr_pick4
    import ram_wport_sched_pkg::*;
(
    input  logic [3:0]  valid,
    input  logic [1:0]  rr,
    input  logic [15:0] eq,     // eq[i*4+j] = (addr_i == addr_j)
    output logic [1:0]  a_idx,
    output logic [1:0]  b_idx,
    output logic        a_vld,
    output logic        b_vld
);

    logic [1:0] idx;

    always_comb begin
        a_idx = '0;
        b_idx = '0;
        a_vld = 1'b0;
        b_vld = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = rr + 2'(k);
            if (valid[idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = idx;
                end else if (!b_vld && !eq[{a_idx, idx}]) begin
                    b_vld = 1'b1;
                    b_idx = idx;
                end
            end
        end
    end

endmodule

// File: rtl/ram_wport_sched.sv
// Shares the two RAM write ports among four writeback requesters and
// zero-fills the RAM after reset or on clear.
module ram_wport_sched
    import ram_wport_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = `DATA_LEN,
    parameter int DEPTH      = 32
) (
    input  logic                    clk,
    input  logic                    reset_x,
    input  logic                    clear,
    input  logic [3:0]              req_valid,
    input  logic [4*ADDR_WIDTH-1:0] req_addr,
    input  logic [4*DATA_WIDTH-1:0] req_data,
    output logic [3:0]              req_ready,
    output logic                    we1,
    output logic                    we2,
    output logic [ADDR_WIDTH-1:0]   waddr1,
    output logic [ADDR_WIDTH-1:0]   waddr2,
    output logic [DATA_WIDTH-1:0]   wdata1,
    output logic [DATA_WIDTH-1:0]   wdata2,
    output logic                    init_busy
);

    localparam int unsigned CNT_LAST = DEPTH / 2 - 1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [1:0]              rr, rr_nxt;
    logic [15:0]             eq;
    logic [1:0]              a_idx, b_idx;
    logic                    a_vld, b_vld;
    logic [ADDR_WIDTH-1:0]   addr_a, addr_b;
    logic [DATA_WIDTH-1:0]   data_a, data_b;

    always_comb begin
        eq = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                eq[i*NREQ + j] = (`WPS_SLICE(req_addr, i, ADDR_WIDTH) ==
                                  `WPS_SLICE(req_addr, j, ADDR_WIDTH));
            end
        end
    end

    rr_pick4 u_pick (
        .valid (req_valid),
        .rr    (rr),
        .eq    (eq),
        .a_idx (a_idx),
        .b_idx (b_idx),
        .a_vld (a_vld),
        .b_vld (b_vld)
    );

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        data_a = '0;
        data_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (a_idx == 2'(i)) begin
                addr_a = `WPS_SLICE(req_addr, i, ADDR_WIDTH);
                data_a = `WPS_SLICE(req_data, i, DATA_WIDTH);
            end
            if (b_idx == 2'(i)) begin
                addr_b = `WPS_SLICE(req_addr, i, ADDR_WIDTH);
                data_b = `WPS_SLICE(req_data, i, DATA_WIDTH);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr;
        req_ready = '0;
        case (state)
            ST_INIT: begin
                if (clear) begin
                    cnt_nxt = '0;
                end else if (cnt == ADDR_WIDTH'(CNT_LAST)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end else begin
                    if (a_vld) begin
                        req_ready[a_idx] = 1'b1;
                        rr_nxt           = rr_after(a_idx);
                    end
                    if (b_vld) begin
                        req_ready[b_idx] = 1'b1;
                        rr_nxt           = rr_after(b_idx);
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign init_busy = (state == ST_INIT);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state  <= ST_INIT;
            cnt    <= '0;
            rr     <= '0;
            we1    <= 1'b0;
            we2    <= 1'b0;
            waddr1 <= '0;
            waddr2 <= '0;
            wdata1 <= '0;
            wdata2 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rr    <= rr_nxt;
            if (state == ST_INIT) begin
                we1    <= 1'b1;
                we2    <= 1'b1;
                waddr1 <= ADDR_WIDTH'({cnt, 1'b0});
                waddr2 <= ADDR_WIDTH'({cnt, 1'b1});
                wdata1 <= '0;
                wdata2 <= '0;
            end else if (clear) begin
                we1 <= 1'b0;
                we2 <= 1'b0;
            end else begin
                // Addresses and data hold their last value on idle ports.
                we1 <= a_vld;
                we2 <= b_vld;
                if (a_vld) begin
                    waddr1 <= addr_a;
                    wdata1 <= data_a;
                end
                if (b_vld) begin
                    waddr2 <= addr_b;
                    wdata2 <= data_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_wport_sched.sv
// Scoreboard bench for ram_wport_sched: directed scenarios followed by
// randomized traffic against a priority-list reference model.
module tb_ram_wport_sched;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            reset_x;
    logic            clear;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic            we1, we2;
    logic [AW-1:0]   waddr1, waddr2;
    logic [DW-1:0]   wdata1, wdata2;
    logic            init_busy;

    ram_wport_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_x   (reset_x),
        .clear     (clear),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we1       (we1),
        .we2       (we2),
        .waddr1    (waddr1),
        .waddr2    (waddr2),
        .wdata1    (wdata1),
        .wdata2    (wdata2),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          m_out;
    int            checks = 0;
    int            errors = 0;
    logic [3:0]    pv;
    logic [AW-1:0] pa[4];
    logic [DW-1:0] pd[4];
    logic [DW-1:0] exp_mem[DEPTH];
    logic [DW-1:0] dut_mem[DEPTH];
    int            m_run;
    int            m_cnt;
    int            m_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: each cycle compares the presented write ports with the
    // oldest expectation and plays the role of the RAM.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we1", 64'(we1), 64'(e.we1));
                chk("waddr1", 64'(waddr1), 64'(e.a1));
                chk("wdata1", 64'(wdata1), 64'(e.d1));
                chk("we2", 64'(we2), 64'(e.we2));
                chk("waddr2", 64'(waddr2), 64'(e.a2));
                chk("wdata2", 64'(wdata2), 64'(e.d2));
                if (we1) dut_mem[waddr1] = wdata1;
                if (we2) dut_mem[waddr2] = wdata2;
            end
        end
    end

    // One clock of stimulus: drive pending requests, predict the outcome.
    task automatic step(input logic rst, input logic clr);
        exp_t       e;
        logic [3:0] rdy;
        logic       busy;
        int         prio[$];
        int         a, b;
        @(negedge clk);
        reset_x = rst;
        clear   = clr;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = pv[i];
            req_addr[i*AW +: AW]  = pa[i];
            req_data[i*DW +: DW]  = pd[i];
        end
        #1;
        rdy = '0;
        e   = m_out;
        e.we1 = 1'b0;
        e.we2 = 1'b0;
        if (!rst) begin
            m_run = 0; m_cnt = 0; m_rr = 0;
            e = '0;
            busy = 1'b1;
            chk("reset_outputs", {we1, we2, waddr1, waddr2, wdata1, wdata2}, 64'd0);
        end else if (m_run == 0) begin
            busy = 1'b1;
            e.we1 = 1'b1; e.a1 = AW'(2 * m_cnt);     e.d1 = '0;
            e.we2 = 1'b1; e.a2 = AW'(2 * m_cnt + 1); e.d2 = '0;
            exp_mem[2 * m_cnt]     = '0;
            exp_mem[2 * m_cnt + 1] = '0;
            if (clr) m_cnt = 0;
            else if (m_cnt == DEPTH / 2 - 1) begin m_run = 1; m_cnt = 0; end
            else m_cnt++;
        end else begin
            busy = 1'b0;
            if (clr) begin
                m_run = 0; m_cnt = 0;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (pv[(m_rr + k) % 4]) prio.push_back((m_rr + k) % 4);
                a = -1; b = -1;
                if (prio.size() > 0) a = prio[0];
                foreach (prio[j])
                    if (b < 0 && j > 0 && pa[prio[j]] != pa[a]) b = prio[j];
                if (a >= 0) begin
                    rdy[a] = 1'b1;
                    e.we1 = 1'b1; e.a1 = pa[a]; e.d1 = pd[a];
                    exp_mem[pa[a]] = pd[a];
                    pv[a] = 1'b0;
                    m_rr = (a + 1) % 4;
                end
                if (b >= 0) begin
                    rdy[b] = 1'b1;
                    e.we2 = 1'b1; e.a2 = pa[b]; e.d2 = pd[b];
                    exp_mem[pa[b]] = pd[b];
                    pv[b] = 1'b0;
                    m_rr = (b + 1) % 4;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(rdy));
        chk("init_busy", 64'(init_busy), 64'(busy));
        m_out = e;
        exp_q.push_back(e);
    endtask

    task automatic readback();
        @(posedge clk);
        #2;
        for (int i = 0; i < DEPTH; i++) chk("ram_readback", 64'(dut_mem[i]), 64'(exp_mem[i]));
    endtask

    task automatic put(input int i, input int addr, input int data);
        pv[i] = 1'b1;
        pa[i] = AW'(addr);
        pd[i] = DW'(data);
    endtask

    initial begin
        reset_x = 1'b0; clear = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        pv = '0; m_out = '0; m_run = 0; m_cnt = 0; m_rr = 0;
        for (int i = 0; i < 4; i++) begin pa[i] = '0; pd[i] = '0; end
        for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = 16'hBEEF; dut_mem[i] = 16'hBEEF; end

        repeat (3) step(1'b0, 1'b0);
        // Requests already pending during the fill must wait for RUN.
        put(0, 10, 16'h1000); put(1, 11, 16'h1111); put(2, 12, 16'h2222); put(3, 13, 16'h3333);
        repeat (16) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        readback();

        put(0, 5, 16'hA5A0); put(1, 5, 16'hA5A1); put(2, 7, 16'hA7A2);
        repeat (3) step(1'b1, 1'b0);

        for (int c = 0; c < 5; c++) begin
            put(3, 20 + c, 16'h3000 + c);
            step(1'b1, 1'b0);
        end
        readback();

        put(0, 1, 16'h0D01); put(1, 2, 16'h0D02); put(2, 3, 16'h0D03);
        step(1'b1, 1'b1);
        repeat (16) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        readback();

        step(1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (18) step(1'b1, 1'b0);
        readback();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 55)
                    put(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
                else if (pv[i] && $urandom_range(0, 99) < 3)
                    pv[i] = 1'b0;
            end
            step(1'b1, (m_run == 1) && ($urandom_range(0, 99) < 2));
        end
        pv = '0;
        repeat (20) step(1'b1, 1'b0);
        readback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
